keystream_serializer: RTL and testbench

//  Consumer side of the chaotic extractor interface. Requests mantissa triples
//  (ex1/ex2/ex3) from the extractor with enable_extract and captures them on

---
 rtl/keystream_serializer.sv | 178 +++++++++++++++++
 tb/tb_keystream_serializer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keystream_serializer.sv
// keystream_serializer
//   Consumer side of the chaotic extractor interface. Requests a mantissa
//   triple (ex1/ex2/ex3) with a one-cycle enable_extract, captures it on
//   valid_extract, and serialises the low 16 bits of each mantissa into six
//   keystream bytes on a valid/ready stream. The stream ends after a
//   programmed number of bytes.
//
// Ports
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   start            one-cycle pulse, accepted in IDLE only
//   abort            synchronous return to IDLE, no done pulse
//   total_bytes      byte count, sampled on an accepted start
//   enable_extract   one-cycle request to the extractor
//   valid_extract    extractor result strobe
//   ex1, ex2, ex3    extracted mantissas
//   ks_byte          keystream byte
//   ks_valid         ks_byte valid
//   ks_ready         downstream accepts ks_byte
//   busy             high in every state except IDLE
//   done             one-cycle pulse when the stream completes
//   overrun          sticky; set by valid_extract outside WAIT
module keystream_serializer #(
  parameter int EX_W  = 23,
  parameter int LEN_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] total_bytes,
  output logic             enable_extract,
  input  logic             valid_extract,
  input  logic [EX_W-1:0]  ex1,
  input  logic [EX_W-1:0]  ex2,
  input  logic [EX_W-1:0]  ex3,
  output logic [7:0]       ks_byte,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] next_remaining;
  logic [2:0]       idx;
  logic [2:0]       next_idx;
  logic [47:0]      buffer;
  logic [47:0]      next_buffer;
  logic [7:0]       next_ks_byte;
  logic             next_done;
  logic             next_overrun;
  logic             transfer;
  logic             unused_ex_high;

  // Mantissa bits above 16 carry no keystream material.
  assign unused_ex_high = ^{ex1[EX_W-1:16], ex2[EX_W-1:16], ex3[EX_W-1:16]};

  assign transfer = ks_valid && ks_ready;

  // Byte i of the buffer; byte 0 is ex1 low, byte 5 is ex3 high.
  function automatic logic [7:0] buf_byte(input logic [47:0] b, input logic [2:0] i);
    case (i)
      3'd0:    buf_byte = b[7:0];
      3'd1:    buf_byte = b[15:8];
      3'd2:    buf_byte = b[23:16];
      3'd3:    buf_byte = b[31:24];
      3'd4:    buf_byte = b[39:32];
      3'd5:    buf_byte = b[47:40];
      default: buf_byte = 8'h00;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state, datapath and next-output decode.
  always_comb begin
    next_state     = state;
    next_remaining = remaining;
    next_idx       = idx;
    next_buffer    = buffer;
    next_ks_byte   = ks_byte;
    next_done      = 1'b0;
    // A result strobe is only legal while a request is outstanding.
    next_overrun   = overrun | (valid_extract && (state != S_WAIT));
    if (abort) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && (total_bytes != '0)) begin
            next_state     = S_REQ;
            next_remaining = total_bytes;
            next_overrun   = valid_extract;
          end else if (start) begin
            next_done = 1'b1;
          end else begin
            next_state = S_IDLE;
          end
        end
        S_REQ: begin
          next_state = S_WAIT;
        end
        S_WAIT: begin
          if (valid_extract) begin
            next_buffer  = {ex3[15:0], ex2[15:0], ex1[15:0]};
            next_idx     = 3'd0;
            next_ks_byte = ex1[7:0];
            next_state   = S_DRAIN;
          end else begin
            next_state = S_WAIT;
          end
        end
        S_DRAIN: begin
          if (transfer) begin
            next_remaining = remaining - LEN_W'(1);
            next_idx       = idx + 3'd1;
            if (remaining == LEN_W'(1)) begin
              next_state = S_IDLE;
              next_done  = 1'b1;
            end else if (idx == 3'd5) begin
              next_state = S_REQ;
            end else begin
              next_ks_byte = buf_byte(buffer, idx + 3'd1);
            end
          end else begin
            next_state = S_DRAIN;
          end
        end
        default: begin
          next_state = S_IDLE;
        end
      endcase
    end
  end

  // Datapath registers and registered outputs, decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining      <= '0;
      idx            <= 3'd0;
      buffer         <= 48'h0;
      ks_byte        <= 8'h00;
      ks_valid       <= 1'b0;
      enable_extract <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      remaining      <= next_remaining;
      idx            <= next_idx;
      buffer         <= next_buffer;
      ks_byte        <= next_ks_byte;
      ks_valid       <= (next_state == S_DRAIN);
      enable_extract <= (next_state == S_REQ);
      busy           <= (next_state != S_IDLE);
      done           <= next_done;
      overrun        <= next_overrun;
    end
  end

endmodule

// File: tb/tb_keystream_serializer.sv
// Self-checking bench for keystream_serializer: table-driven streams,
// hand-written corner sequences and randomized streams against a
// byte-queue reference model.
module tb_keystream_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [19:0] total_bytes = 20'd0;
  logic        enable_extract;
  logic        valid_extract = 1'b0;
  logic [22:0] ex1 = 23'd0;
  logic [22:0] ex2 = 23'd0;
  logic [22:0] ex3 = 23'd0;
  logic [7:0]  ks_byte;
  logic        ks_valid;
  logic        ks_ready = 1'b0;
  logic        busy;
  logic        done;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [68:0] tq[$];   // triples {ex3,ex2,ex1} the extractor will return
  logic [7:0]  eq[$];   // expected keystream bytes

  typedef struct {
    int           total;
    logic [137:0] trips;     // {triple1, triple0}
    logic [95:0]  bytes;     // byte i at [i*8 +: 8]
    int           exp_reqs;
  } vec_t;

  vec_t vecs[4];

  keystream_serializer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .total_bytes(total_bytes), .enable_extract(enable_extract),
    .valid_extract(valid_extract), .ex1(ex1), .ex2(ex2), .ex3(ex3),
    .ks_byte(ks_byte), .ks_valid(ks_valid), .ks_ready(ks_ready),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_triple(input logic [68:0] t);
    valid_extract = 1'b1;
    ex1 = t[22:0];
    ex2 = t[45:23];
    ex3 = t[68:46];
  endtask

  // Run one stream; tq holds the triples to return, eq the expected bytes.
  task automatic run_stream(input int total, input int exp_reqs, input bit rnd);
    int   reqs = 0;
    bit   pending = 1'b0;
    int   delay = 0;
    bit   vx_prev = 1'b0;
    bit   stall_prev = 1'b0;
    bit   en_prev = 1'b0;
    logic [7:0] byte_prev = 8'h00;
    bit   fin = 1'b0;
    total_bytes = total[19:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    total_bytes = 20'd0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      valid_extract = 1'b0;
      if (cyc == 0 && total != 0) begin
        check("start_to_req", enable_extract, 1);
        check("start_clears_overrun", overrun, 0);
      end
      if (vx_prev) check("ks_valid_after_extract", ks_valid, 1);
      if (stall_prev) begin
        check("hold_valid", ks_valid, 1);
        check("hold_byte", ks_byte, byte_prev);
      end
      if (en_prev) check("req_one_cycle", enable_extract, 0);
      if (done) begin
        fin = 1'b1;
        check("bytes_left_at_done", eq.size(), 0);
        check("request_count", reqs, exp_reqs);
        check("busy_at_done", busy, 0);
        check("ks_valid_at_done", ks_valid, 0);
      end else begin
        if (pending) begin
          if (delay == 0) begin
            pending = 1'b0;
            if (tq.size() == 0) begin
              check("extra_request", 1, 0);
              drive_triple(69'd0);
            end else begin
              drive_triple(tq.pop_front());
            end
          end else begin
            delay--;
          end
        end
        if (enable_extract) begin
          reqs++;
          pending = 1'b1;
          delay = rnd ? int'($urandom_range(0, 3)) : 0;
        end
        ks_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (ks_valid && ks_ready) begin
          if (eq.size() == 0) check("extra_byte", ks_byte, 9'h100);
          else check("ks_byte", ks_byte, eq.pop_front());
        end
        vx_prev = valid_extract;
        stall_prev = ks_valid && !ks_ready;
        byte_prev = ks_byte;
        en_prev = enable_extract;
        tick();
      end
    end
    valid_extract = 1'b0;
    if (!fin) begin
      check("stream_timeout", 0, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    tick();
    check("done_one_cycle", done, 0);
    ks_ready = 1'b0;
  endtask

  initial begin
    logic [68:0] t1;
    logic [68:0] t2;
    logic [95:0] all_bytes;
    logic [68:0] rt;
    int          tot;
    t1 = {23'h09189F, 23'h1622C7, 23'h6419F7};
    t2 = {23'h063380, 23'h0CF6BD, 23'h14DC72};
    all_bytes = {8'h33, 8'h80, 8'hF6, 8'hBD, 8'hDC, 8'h72,
                 8'h18, 8'h9F, 8'h22, 8'hC7, 8'h19, 8'hF7};
    vecs[0] = '{total: 6,  trips: {t2, t1}, bytes: all_bytes, exp_reqs: 1};
    vecs[1] = '{total: 8,  trips: {t2, t1}, bytes: all_bytes, exp_reqs: 2};
    vecs[2] = '{total: 3,  trips: {t2, t1}, bytes: all_bytes, exp_reqs: 1};
    vecs[3] = '{total: 12, trips: {t2, t1}, bytes: all_bytes, exp_reqs: 2};

    // Reset values
    tick();
    check("rst_enable", enable_extract, 0);
    check("rst_ks_valid", ks_valid, 0);
    check("rst_ks_byte", ks_byte, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;
    tick();

    // Table-driven streams
    for (int v = 0; v < 4; v++) begin
      tq.delete();
      eq.delete();
      tq.push_back(vecs[v].trips[68:0]);
      tq.push_back(vecs[v].trips[137:69]);
      for (int i = 0; i < vecs[v].total; i++) eq.push_back(vecs[v].bytes[i*8 +: 8]);
      run_stream(vecs[v].total, vecs[v].exp_reqs, 1'b0);
    end

    // Zero-length stream
    tq.delete();
    eq.delete();
    run_stream(0, 0, 1'b0);

    // Backpressure at byte 2: C7 held for three stalled cycles
    ks_ready = 1'b1;
    total_bytes = 20'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    drive_triple(t1);
    tick();
    valid_extract = 1'b0;
    check("bp_byte0", ks_byte, 8'hF7);
    tick();
    check("bp_byte1", ks_byte, 8'h19);
    tick();
    check("bp_byte2", ks_byte, 8'hC7);
    ks_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_valid", ks_valid, 1);
      check("bp_hold_byte", ks_byte, 8'hC7);
    end
    ks_ready = 1'b1;
    tick();
    check("bp_byte3", ks_byte, 8'h22);
    tick();
    check("bp_byte4", ks_byte, 8'h9F);
    tick();
    check("bp_byte5", ks_byte, 8'h18);
    tick();
    check("bp_done", done, 1);
    check("bp_ks_valid_low", ks_valid, 0);
    tick();
    ks_ready = 1'b0;

    // Asynchronous reset while draining at idx 3
    ks_ready = 1'b1;
    total_bytes = 20'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    drive_triple(t1);
    tick();
    valid_extract = 1'b0;
    tick();
    tick();
    tick();
    check("rs_idx3_byte", ks_byte, 8'h22);
    ks_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("rs_ks_valid", ks_valid, 0);
    check("rs_busy", busy, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive_triple(t1);    // late result from the aborted request
    tick();
    valid_extract = 1'b0;
    check("rs_late_overrun", overrun, 1);
    check("rs_late_no_valid", ks_valid, 0);
    tq.delete();
    eq.delete();
    tq.push_back(t2);
    for (int i = 0; i < 6; i++) eq.push_back(all_bytes[48 + i*8 +: 8]);
    run_stream(6, 1, 1'b0);

    // Overrun in IDLE, cleared by start; abort in WAIT
    drive_triple(t2);
    tick();
    valid_extract = 1'b0;
    check("ov_set", overrun, 1);
    check("ov_no_valid", ks_valid, 0);
    tick();
    check("ov_sticky", overrun, 1);
    total_bytes = 20'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ov_cleared", overrun, 0);
    tick();
    check("ab_in_wait_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_done", done, 0);
    check("ab_ks_valid", ks_valid, 0);
    tick();
    check("ab_done_later", done, 0);
    check("ab_enable", enable_extract, 0);
    // abort beats start in the same cycle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("ab_start_busy", busy, 0);
    check("ab_start_enable", enable_extract, 0);
    tick();
    check("ab_start_enable2", enable_extract, 0);

    // Randomized streams against the byte-queue model
    for (int s = 0; s < 25; s++) begin
      tot = int'($urandom_range(0, 20));
      tq.delete();
      eq.delete();
      for (int k = 0; k < (tot + 5) / 6; k++) begin
        rt = {23'($urandom()), 23'($urandom()), 23'($urandom())};
        tq.push_back(rt);
        for (int b = 0; b < 3; b++) begin
          if (eq.size() < tot) eq.push_back(rt[b*23 +: 8]);
          if (eq.size() < tot) eq.push_back(rt[b*23 + 8 +: 8]);
        end
      end
      run_stream(tot, (tot + 5) / 6, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
